rr_onehot_arb: RTL
==================

Name: rr_onehot_arb

Overview:
- Round-robin arbiter for N requesters.
- Produces the registered one-hot select vector that drives the downstream one-hot mux's 4-bit sel input, plus a binary index of the grant.
- Replaces static/priority select generation so no requester starves.
- Supports a hold input that locks the current grant for multi-cycle transfers.

Parameters:
- N, 4, number of requesters; one-hot width of sel_o; legal range 2..16.
- IDXW, $clog2(N), width of gnt_idx_o; derived, not overridden.

Ports:
- clk  input  1  rising-edge clock.
- reset_n  input  1  asynchronous active-low reset.
- req_i  input  N  request vector; bit k high = requester k wants the mux.
- hold_i  input  1  keep the current grant while its requester still requests.
- sel_o  output  N  registered one-hot grant; all-zero when idle; connects to the mux select.
- gnt_valid_o  output  1  high when sel_o has exactly one bit set.
- gnt_idx_o  output  IDXW  binary index of the set bit in sel_o; 0 when idle.

Behaviour:
- Reset:
  - Reset is asynchronous active-low.
  - While reset_n is low: sel_o=0, gnt_valid_o=0, gnt_idx_o=0, internal last-grant pointer ptr=N-1. With ptr=N-1, requester 0 has top priority after reset.
  - Deassertion takes effect on the next rising clk edge; no grant is issued in the cycle reset releases.
  - Reset asserted mid-grant clears all outputs immediately (asynchronously), regardless of hold_i.
- Timing:
  - All outputs come from flops. There is no combinational path from req_i or hold_i to any output.
  - Latency is 1 cycle: the req_i/hold_i sampled at edge t determines sel_o after edge t.
- Next-state decision at each edge, in priority order:
  1. Hold: if gnt_valid_o=1, hold_i=1 and req_i[gnt_idx_o]=1, the grant is unchanged and ptr is unchanged.
  2. New grant: otherwise, if req_i is non-zero, search circularly from ptr+1 (wrapping N-1 -> 0) and grant the first k with req_i[k]=1. The search covers all N slots, so ptr itself is checked last. Set sel_o=onehot(k), gnt_idx_o=k, gnt_valid_o=1, ptr=k.
  3. Idle: otherwise (req_i=0), sel_o=0, gnt_valid_o=0, gnt_idx_o=0; ptr is retained so fairness survives idle gaps.
- Release: a granted requester that drops its req is released at the next edge even if hold_i=1. The rotation then continues from that requester.
- hold_i is ignored while gnt_valid_o=0.
- Without hold_i, a requester that keeps requesting loses the grant to any other requester at the next edge. If it is the sole requester, it is re-granted every cycle.
- Invariants, checked by assertion in the bench:
  - sel_o is always zero or exactly one-hot ($onehot0).
  - gnt_valid_o == |sel_o.
  - When valid, sel_o == 1<<gnt_idx_o.
  - When valid, the granted requester had req_i set at the sampling edge.
- No X propagation: X on req_i must not be masked. The bench drives known values only.
- The state machine is implicit in the registers: the states are IDLE (valid=0) and GRANT(k).
  - IDLE -> GRANT(k) on any request.
  - GRANT(k) -> GRANT(k) on hold.
  - GRANT(k) -> GRANT(j) on rotation.
  - GRANT(k) -> IDLE when req_i=0.

Test Plan:
1. Reset, then req_i=4'b1111, hold_i=0 for 5 cycles -> sel_o sequence 0001,0010,0100,1000,0001; gnt_idx_o 0,1,2,3,0; gnt_valid_o=1 throughout.
2. Sparse wrap: after a grant to index 2, set req_i=4'b0011 -> sel_o=0001 next cycle, then 0010, then 0001. Confirms wrap from 3 to 0 and fair alternation.
3. Hold: req_i=4'b1010 with hold_i=1 -> sel_o=0010 held for 4 cycles. Then drop req_i[1] -> sel_o=1000 next cycle. Then hold_i=0 with req_i=4'b1010 -> sel_o alternates 0010/1000.
4. Idle gap: grant index 1 with req_i=4'b0010, then req_i=0 for 3 cycles -> sel_o=0, gnt_valid_o=0, gnt_idx_o=0. Then req_i=4'b0011 -> sel_o=0001, because ptr was retained at 1.
5. Asynchronous reset mid-grant: while sel_o=0100 and hold_i=1, pulse reset_n low between clock edges -> outputs clear immediately. After release with req_i=4'b1100 -> first grant is sel_o=0100.
6. Integration: feed sel_o into the one-hot mux with a=4'b1010, req_i=4'b1111 -> mux output per cycle is 0,1,0,1, matching a[gnt_idx_o]. Run 1000 random req_i/hold_i cycles with the invariant assertions active and zero failures.

Source files
------------

// File: rtl/rr_onehot_arb.sv
// Round-robin arbiter with a registered one-hot select and binary grant index.
// An optional hold input keeps the current grant for multi-cycle transfers.
module rr_onehot_arb #(
    parameter int N = 4
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [N-1:0]         req_i,
    input  logic                 hold_i,
    output logic [N-1:0]         sel_o,
    output logic                 gnt_valid_o,
    output logic [$clog2(N)-1:0] gnt_idx_o
);

    localparam int IDXW = $clog2(N);

    logic [N-1:0]    sel_r;
    logic            valid_r;
    logic [IDXW-1:0] idx_r;
    logic [IDXW-1:0] ptr_r;

    logic            hold_s;
    logic            found_s;
    logic [IDXW-1:0] next_idx_s;

    function automatic logic [N-1:0] onehot(input logic [IDXW-1:0] idx);
        onehot = N'(1) << idx;
    endfunction

    // Hold only applies to a live grant whose requester is still asking.
    assign hold_s = valid_r & hold_i & req_i[idx_r];

    // Circular search starting just after the last grant; ptr itself is checked last.
    always_comb begin
        int cand;
        found_s    = 1'b0;
        next_idx_s = '0;
        cand       = 0;
        for (int i = 1; i <= N; i++) begin
            cand = (int'(ptr_r) + i) % N;
            if (!found_s && req_i[cand[IDXW-1:0]]) begin
                found_s    = 1'b1;
                next_idx_s = cand[IDXW-1:0];
            end else begin
                found_s    = found_s;
            end
        end
    end

    // Grant state: hold, new grant or idle; ptr survives idle gaps.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sel_r   <= '0;
            valid_r <= 1'b0;
            idx_r   <= '0;
            ptr_r   <= IDXW'(N - 1);
        end else if (hold_s) begin
            sel_r   <= sel_r;
            valid_r <= valid_r;
            idx_r   <= idx_r;
            ptr_r   <= ptr_r;
        end else if (found_s) begin
            sel_r   <= onehot(next_idx_s);
            valid_r <= 1'b1;
            idx_r   <= next_idx_s;
            ptr_r   <= next_idx_s;
        end else begin
            sel_r   <= '0;
            valid_r <= 1'b0;
            idx_r   <= '0;
            ptr_r   <= ptr_r;
        end
    end

    assign sel_o       = sel_r;
    assign gnt_valid_o = valid_r;
    assign gnt_idx_o   = idx_r;

endmodule
